// File: rtl/lcd_read_controller_if.sv
// Request/response handshake and LCD parallel-bus signals of the LCD read controller.
// The master side issues read requests and supplies the bus; the slave side is the controller.
interface lcd_read_controller_if;
    logic       rd_start;
    logic       rd_rs;
    logic       rd_busy;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       rd_timeout;
    logic [7:0] lcd_data_in;
    logic       lcd_en;
    logic       lcd_rw;
    logic       lcd_rs;

    modport master (
        output rd_start, rd_rs, lcd_data_in,
        input  rd_busy, rd_done, rd_data, rd_timeout, lcd_en, lcd_rw, lcd_rs
    );

    modport slave (
        input  rd_start, rd_rs, lcd_data_in,
        output rd_busy, rd_done, rd_data, rd_timeout, lcd_en, lcd_rw, lcd_rs
    );
endinterface

// File: rtl/lcd_read_controller.sv
// HD44780-style LCD read cycle: RW=1, EN pulse, capture of the 8-bit bus.
// Define LCD_BF_POLL_EN to turn RS=0 requests into busy-flag polls bounded by MAX_POLL.
module lcd_read_controller #(
    parameter int SETUP_CYC   = 2,
    parameter int EN_HIGH_CYC = 16,
    parameter int HOLD_CYC    = 2,
    parameter int MAX_POLL    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_read_controller_if.slave bus
);
    localparam int CNT_MAX = (SETUP_CYC > EN_HIGH_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((EN_HIGH_CYC > HOLD_CYC) ? EN_HIGH_CYC : HOLD_CYC);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LOAD    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

    generate
        if (SETUP_CYC < 1 || EN_HIGH_CYC < 1 || HOLD_CYC < 1 || MAX_POLL < 1) begin : g_bad_param
            $error("lcd_read_controller: all timing parameters and MAX_POLL must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          capture;
    logic          hold_end;
    logic          repoll;

    // The bus is sampled on the edge that ends the final EN_HI cycle, i.e. as lcd_en falls.
    assign capture  = (state_q == S_EN_HI) && (cnt_q == '0);
    assign hold_end = (state_q == S_HOLD)  && (cnt_q == '0);
    assign bus.rd_data = data_q;

`ifdef LCD_BF_POLL_EN
    localparam int PW = $clog2(MAX_POLL + 1);

    logic [PW-1:0] polls_q;
    logic          timeout_q;

    // A status poll repeats while the busy flag (bit 7) is still set and reads remain.
    assign repoll = !rs_q && data_q[7] && (polls_q < PW'(MAX_POLL));
    assign bus.rd_timeout = (state_q == S_DONE) && timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            polls_q   <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == S_IDLE && bus.rd_start) begin
            polls_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (capture) begin
                polls_q <= polls_q + 1'b1;
            end
            if (hold_end) begin
                timeout_q <= !rs_q && data_q[7];
            end
        end
    end
`else
    assign repoll         = 1'b0;
    assign bus.rd_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && bus.rd_start) begin
                rs_q <= bus.rd_rs;
            end
            if (capture) begin
                data_q <= bus.lcd_data_in;
            end
        end
    end

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus.lcd_en  = 1'b0;
        bus.lcd_rw  = 1'b0;
        bus.lcd_rs  = 1'b0;
        bus.rd_busy = 1'b1;
        bus.rd_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.rd_busy = 1'b0;
                if (bus.rd_start) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LOAD;
                end
            end
            S_SETUP: begin
                bus.lcd_rw = 1'b1;
                bus.lcd_rs = rs_q;
                if (cnt_q == '0) begin
                    state_d = S_EN_HI;
                    cnt_d   = EN_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EN_HI: begin
                bus.lcd_en = 1'b1;
                bus.lcd_rw = 1'b1;
                bus.lcd_rs = rs_q;
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                bus.lcd_rw = 1'b1;
                bus.lcd_rs = rs_q;
                if (cnt_q == '0) begin
                    if (repoll) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                bus.rd_done = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_lcd_read_controller.sv
// Self-checking bench for lcd_read_controller: directed scenarios plus randomized requests
// compared cycle by cycle against a timeline model derived from the read-cycle timing rules.
module tb_lcd_read_controller;
    localparam int S      = 2;
    localparam int E      = 16;
    localparam int H      = 2;
    localparam int MP     = 4;
    localparam int PERIOD = S + E + H;

    logic clk;
    logic reset;

    lcd_read_controller_if bus ();

    lcd_read_controller #(
        .SETUP_CYC  (S),
        .EN_HIGH_CYC(E),
        .HOLD_CYC   (H),
        .MAX_POLL   (MP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_data;
    logic [7:0] rd_bytes [0:MP-1];

    always #5 clk = ~clk;

    // Runs one request starting in the current cycle (cycle 0) and checks every cycle
    // through DONE plus 'tail' idle cycles. rd_bytes[i] is the bus value at the sample
    // point of read i; every other cycle carries junk.
    task automatic run_request(input string name, input logic rs, input bit fixed_junk,
                               input logic [7:0] junk, input bit inject, input int tail);
        int          n;
        bit          poll;
        bit          tmo;
        int          done_cyc;
        int          pos;
        int          idx;
        int          en_rises;
        bit          in_read;
        bit          sample;
        logic        prev_en;
        logic [13:0] got;
        logic [13:0] exp;

        poll = 1'b0;
`ifdef LCD_BF_POLL_EN
        poll = (rs == 1'b0);
`endif
        n   = 1;
        tmo = 1'b0;
        if (poll) begin
            n   = MP;
            tmo = 1'b1;
            for (int i = 0; i < MP; i++) begin
                if (!rd_bytes[i][7]) begin
                    n   = i + 1;
                    tmo = 1'b0;
                    break;
                end
            end
        end
        done_cyc = 1 + n * PERIOD;
        en_rises = 0;
        prev_en  = 1'b0;

        for (int k = 0; k <= done_cyc + tail; k++) begin
            in_read = (k >= 1) && (k <= n * PERIOD);
            pos     = in_read ? (k - 1) % PERIOD : 0;
            idx     = in_read ? (k - 1) / PERIOD : 0;
            sample  = in_read && (pos == S + E - 1);

            bus.rd_start    = (k == 0) || (inject && (k == 5 || k == done_cyc));
            bus.rd_rs       = (k == 0) ? rs : 1'($urandom);
            bus.lcd_data_in = sample ? rd_bytes[idx] : (fixed_junk ? junk : 8'($urandom));

            @(negedge clk);
            exp = {in_read && pos >= S && pos < S + E,
                   in_read,
                   in_read && rs,
                   (k >= 1) && (k <= done_cyc),
                   k == done_cyc,
                   (k == done_cyc) && tmo,
                   exp_data};
            got = {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.rd_busy,
                   bus.rd_done, bus.rd_timeout, bus.rd_data};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d {en,rw,rs,busy,done,tmo,data} got %b_%h expected %b_%h",
                         name, k, got[13:8], got[7:0], exp[13:8], exp[7:0]);
            end
            if (bus.lcd_en && !prev_en) en_rises++;
            prev_en = bus.lcd_en;

            @(posedge clk);
            if (sample) exp_data = rd_bytes[idx];
            #1;
        end
        bus.rd_start = 1'b0;

        checks++;
        if (en_rises !== n) begin
            errors++;
            $display("FAIL %s en_pulses got %0d expected %0d", name, en_rises, n);
        end
    endtask

    task automatic test_reset();
        logic [13:0] got;
        reset           = 1'b1;
        bus.rd_start    = 1'b1;
        bus.rd_rs       = 1'b1;
        bus.lcd_data_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.rd_start = 1'b0;
        exp_data     = 8'h00;
        // A start held alongside reset must not have launched a read.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.rd_busy,
                   bus.rd_done, bus.rd_timeout, bus.rd_data};
            checks++;
            if (got !== 14'h0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got %h expected 0000", i, got);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_data_read();
        rd_bytes[0] = 8'hA5;
        run_request("data_read", 1'b1, 1'b1, 8'hA5, 1'b0, 2);
    endtask

    task automatic test_status_read();
        rd_bytes[0] = 8'h7E;
        run_request("status_read", 1'b0, 1'b1, 8'h3C, 1'b0, 2);
    endtask

    task automatic test_ignored_start();
        rd_bytes[0] = 8'h5A;
        run_request("ignored_start", 1'b1, 1'b0, 8'h00, 1'b1, 3);
    endtask

    task automatic test_back_to_back();
        rd_bytes[0] = 8'h11;
        run_request("b2b_first", 1'b1, 1'b0, 8'h00, 1'b0, 0);
        rd_bytes[0] = 8'h22;
        run_request("b2b_second", 1'b1, 1'b0, 8'h00, 1'b0, 1);
    endtask

    task automatic test_reset_mid_read();
        logic [13:0] got;
        bus.rd_start    = 1'b1;
        bus.rd_rs       = 1'b1;
        bus.lcd_data_in = 8'hC3;
        @(posedge clk);
        #1;
        bus.rd_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.lcd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_en_before_reset got %b expected 1", bus.lcd_en);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        exp_data = 8'h00;
        for (int i = 0; i < PERIOD + 4; i++) begin
            @(negedge clk);
            got = {bus.lcd_en, bus.lcd_rw, bus.lcd_rs, bus.rd_busy,
                   bus.rd_done, bus.rd_timeout, bus.rd_data};
            checks++;
            if (got !== 14'h0) begin
                errors++;
                $display("FAIL mid_read_reset cycle %0d got %h expected 0000", i, got);
            end
            @(posedge clk);
            #1;
        end
        rd_bytes[0] = 8'h96;
        run_request("after_reset", 1'b1, 1'b0, 8'h00, 1'b0, 1);
    endtask

`ifdef LCD_BF_POLL_EN
    task automatic test_poll();
        rd_bytes[0] = 8'h80;
        rd_bytes[1] = 8'h80;
        rd_bytes[2] = 8'h05;
        rd_bytes[3] = 8'h80;
        run_request("poll_ready", 1'b0, 1'b0, 8'h00, 1'b0, 1);
        for (int i = 0; i < MP; i++) rd_bytes[i] = 8'h80;
        run_request("poll_timeout", 1'b0, 1'b0, 8'h00, 1'b0, 1);
    endtask
`endif

    task automatic test_random();
        logic rs;
        for (int t = 0; t < 24; t++) begin
            rs = 1'($urandom);
            for (int i = 0; i < MP; i++) begin
                rd_bytes[i] = 8'($urandom);
                if ($urandom_range(0, 3) != 0) rd_bytes[i][7] = 1'b1;
            end
            run_request("random", rs, 1'b0, 8'h00, 1'($urandom),
                        int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        clk             = 1'b0;
        reset           = 1'b1;
        bus.rd_start    = 1'b0;
        bus.rd_rs       = 1'b0;
        bus.lcd_data_in = 8'h00;
        exp_data        = 8'h00;

        test_reset();
        test_data_read();
        test_status_read();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_read();
`ifdef LCD_BF_POLL_EN
        test_poll();
`endif
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
